// File: rtl/fib_check_pkg.sv
// fib_check_pkg: types and constants shared by the Fibonacci stream checker.
//   fib_check_state_t : checker FSM states (IDLE, RUN, ERR)
//   FIB_SEED0/1       : first two numbers of the expected sequence
// Optional feature macro used by the checker files: FIB_CHECK_DUAL_EN.
package fib_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } fib_check_state_t;

  localparam int FIB_SEED0 = 1;
  localparam int FIB_SEED1 = 1;

endpackage

// File: rtl/fib_expect_gen.sv
// fib_expect_gen: holds the next two expected Fibonacci numbers (mod 2^W).
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   load_seed       : synchronous reload of the seed pair {1, 1}
//   advance         : step the sequence (one beat accepted)
//   step2           : (FIB_CHECK_DUAL_EN only) advance by two numbers per step
//   exp_a, exp_b    : current expected pair
// Macro: FIB_CHECK_DUAL_EN selects the two-numbers-per-step variant.
module fib_expect_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_seed,
  input  logic         advance,
`ifdef FIB_CHECK_DUAL_EN
  input  logic         step2,
`endif
  output logic [W-1:0] exp_a,
  output logic [W-1:0] exp_b
);
  import fib_check_pkg::*;

  logic [W-1:0] exp_a_q, exp_a_d;
  logic [W-1:0] exp_b_q, exp_b_d;

  // Next expected pair: reload, step by one or two, or hold.
  always_comb begin
    exp_a_d = exp_a_q;
    exp_b_d = exp_b_q;
    if (load_seed) begin
      exp_a_d = W'(FIB_SEED0);
      exp_b_d = W'(FIB_SEED1);
    end else if (advance) begin
`ifdef FIB_CHECK_DUAL_EN
      if (step2) begin
        // F(n+2) = a + b, F(n+3) = a + 2b; sums wrap at W bits.
        exp_a_d = exp_a_q + exp_b_q;
        exp_b_d = exp_a_q + (exp_b_q << 1);
      end else begin
        exp_a_d = exp_b_q;
        exp_b_d = exp_a_q + exp_b_q;
      end
`else
      exp_a_d = exp_b_q;
      exp_b_d = exp_a_q + exp_b_q;
`endif
    end else begin
      exp_a_d = exp_a_q;
      exp_b_d = exp_b_q;
    end
  end

  // Expected-pair register, seeded on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_a_q <= W'(FIB_SEED0);
      exp_b_q <= W'(FIB_SEED1);
    end else begin
      exp_a_q <= exp_a_d;
      exp_b_q <= exp_b_d;
    end
  end

  assign exp_a = exp_a_q;
  assign exp_b = exp_b_q;

endmodule

// File: rtl/fibonacci_checker.sv
// fibonacci_checker: consumes a valid/ready stream of Fibonacci numbers
// (mod 2^W, starting 1, 1), counts matches and captures the first mismatch.
// After a mismatch the stream is stalled (in_ready low) until clear or reset.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   clear                 : synchronous restart to IDLE, wipes counters/capture
//   in_valid / in_ready   : stream handshake (in_ready is combinational)
//   in_num                : lane 0 value
//   in_num2               : lane 1 value (FIB_CHECK_DUAL_EN only)
//   busy                  : state is RUN
//   match_cnt             : saturating count of verified numbers
//   err                   : sticky mismatch flag
//   err_idx/err_exp/err_got : index, expected and received value of 1st mismatch
// Macro: FIB_CHECK_DUAL_EN enables the two-lane (double-rate) mode.
module fibonacci_checker #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_num,
`ifdef FIB_CHECK_DUAL_EN
  input  logic [W-1:0]     in_num2,
`endif
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt,
  output logic             err,
  output logic [CNT_W-1:0] err_idx,
  output logic [W-1:0]     err_exp,
  output logic [W-1:0]     err_got
);
  import fib_check_pkg::*;

  fib_check_state_t state_q, state_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_idx_q, err_idx_d;
  logic [W-1:0]     err_exp_q, err_exp_d;
  logic [W-1:0]     err_got_q, err_got_d;

  logic [W-1:0]     exp_a;
  logic             accept_s;
  logic             mismatch_s;
  logic             mis_lane_s;
  logic [1:0]       inc_s;
  logic [CNT_W:0]   cnt_sum_s;
  logic [CNT_W:0]   idx_sum_s;
  logic [CNT_W-1:0] cnt_sat_s;
  logic [CNT_W-1:0] idx_sat_s;

`ifdef FIB_CHECK_DUAL_EN
  logic [W-1:0]     exp_b;
`else
  logic [W-1:0]     lane1_exp_unused;
`endif

  fib_expect_gen #(.W(W)) u_expect (
    .clk       (clk),
    .rst       (rst),
    .load_seed (clear),
    .advance   (accept_s),
`ifdef FIB_CHECK_DUAL_EN
    .step2     (1'b1),
    .exp_a     (exp_a),
    .exp_b     (exp_b)
`else
    .exp_a     (exp_a),
    .exp_b     (lane1_exp_unused)
`endif
  );

  assign in_ready = (state_q != ERR) && !clear;
  assign accept_s = in_valid && in_ready;

  // Per-beat lane comparison: mismatch flag, failing lane and match increment.
  always_comb begin
    mismatch_s = 1'b0;
    mis_lane_s = 1'b0;
    inc_s      = 2'd0;
`ifdef FIB_CHECK_DUAL_EN
    if (in_num != exp_a) begin
      // Lane 0 wins when both lanes are wrong; nothing is counted.
      mismatch_s = 1'b1;
      mis_lane_s = 1'b0;
      inc_s      = 2'd0;
    end else if (in_num2 != exp_b) begin
      mismatch_s = 1'b1;
      mis_lane_s = 1'b1;
      inc_s      = 2'd1;
    end else begin
      inc_s      = 2'd2;
    end
`else
    if (in_num != exp_a) begin
      mismatch_s = 1'b1;
      inc_s      = 2'd0;
    end else begin
      inc_s      = 2'd1;
    end
`endif
  end

  // One extra bit catches the carry so both values can saturate at all-ones.
  assign cnt_sum_s = {1'b0, match_cnt_q} + {{(CNT_W-1){1'b0}}, inc_s};
  assign idx_sum_s = {1'b0, match_cnt_q} + {{CNT_W{1'b0}}, mis_lane_s};
  assign cnt_sat_s = cnt_sum_s[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];
  assign idx_sat_s = idx_sum_s[CNT_W] ? {CNT_W{1'b1}} : idx_sum_s[CNT_W-1:0];

  // FSM next state; clear overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept_s) begin
          state_d = mismatch_s ? ERR : RUN;
        end else begin
          state_d = state_q;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Counter and first-mismatch capture next values.
  always_comb begin
    match_cnt_d = match_cnt_q;
    err_d       = err_q;
    err_idx_d   = err_idx_q;
    err_exp_d   = err_exp_q;
    err_got_d   = err_got_q;
    if (clear) begin
      match_cnt_d = {CNT_W{1'b0}};
      err_d       = 1'b0;
      err_idx_d   = {CNT_W{1'b0}};
      err_exp_d   = {W{1'b0}};
      err_got_d   = {W{1'b0}};
    end else if (accept_s) begin
      match_cnt_d = cnt_sat_s;
      if (mismatch_s) begin
        err_d     = 1'b1;
        err_idx_d = idx_sat_s;
`ifdef FIB_CHECK_DUAL_EN
        if (mis_lane_s) begin
          err_exp_d = exp_b;
          err_got_d = in_num2;
        end else begin
          err_exp_d = exp_a;
          err_got_d = in_num;
        end
`else
        err_exp_d = exp_a;
        err_got_d = in_num;
`endif
      end else begin
        err_d = err_q;
      end
    end else begin
      match_cnt_d = match_cnt_q;
    end
  end

  assign busy_d = (state_d == RUN);

  // State and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      match_cnt_q <= {CNT_W{1'b0}};
      err_q       <= 1'b0;
      err_idx_q   <= {CNT_W{1'b0}};
      err_exp_q   <= {W{1'b0}};
      err_got_q   <= {W{1'b0}};
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
      err_idx_q   <= err_idx_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
    end
  end

  assign busy      = busy_q;
  assign match_cnt = match_cnt_q;
  assign err       = err_q;
  assign err_idx   = err_idx_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker: the driver pushes the predicted
// post-edge status per cycle, a monitor pops and compares after each edge.
// Build with FIB_CHECK_DUAL_EN to exercise the two-lane mode.
module tb_fibonacci_checker;
  localparam int W     = 16;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef FIB_CHECK_DUAL_EN
  localparam int LANES = 2;
`else
  localparam int LANES = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_num;
`ifdef FIB_CHECK_DUAL_EN
  logic [W-1:0]     in_num2;
`endif
  logic             busy;
  logic [CNT_W-1:0] match_cnt;
  logic             err;
  logic [CNT_W-1:0] err_idx;
  logic [W-1:0]     err_exp;
  logic [W-1:0]     err_got;

  always #5 clk = ~clk;

  fibonacci_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
`ifdef FIB_CHECK_DUAL_EN
    .in_num2   (in_num2),
`endif
    .busy      (busy),
    .match_cnt (match_cnt),
    .err       (err),
    .err_idx   (err_idx),
    .err_exp   (err_exp),
    .err_got   (err_got)
  );

  typedef struct {
    bit busy;
    int mcnt;
    bit err;
    int idx;
    int eexp;
    int egot;
  } status_t;

  status_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int fib[1024];

  // Reference model: position in the sequence plus status, all plain integers.
  int m_pos, m_cnt, m_idx, m_exp, m_got;
  bit m_err, m_busy;

  task automatic check(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_pos = 0; m_cnt = 0; m_idx = 0; m_exp = 0; m_got = 0;
    m_err = 1'b0; m_busy = 1'b0;
  endfunction

  function automatic void model_beat(bit v, int n0, int n1, bit clr);
    status_t s;
    int got;
    if (clr) begin
      model_reset();
    end else if (v && !m_err) begin
      for (int l = 0; l < LANES; l++) begin
        got = (l == 0) ? n0 : n1;
        if (got != fib[m_pos + l]) begin
          m_err = 1'b1;
          m_idx = m_cnt;
          m_exp = fib[m_pos + l];
          m_got = got;
          break;
        end
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
      m_pos += LANES;
      m_busy = !m_err;
    end
    s.busy = m_busy; s.mcnt = m_cnt; s.err = m_err;
    s.idx = m_idx; s.eexp = m_exp; s.egot = m_got;
    sb_q.push_back(s);
  endfunction

  // One cycle of stimulus: drive at negedge, check in_ready, predict the edge.
  task automatic drive(bit v, int n0, int n1, bit clr);
    @(negedge clk);
    in_valid = v;
    in_num   = W'(n0);
`ifdef FIB_CHECK_DUAL_EN
    in_num2  = W'(n1);
`endif
    clear    = clr;
    #1;
    check("in_ready", in_ready, (!m_err && !clr) ? 1 : 0);
    model_beat(v, n0, n1, clr);
  endtask

  task automatic good_beat();
    drive(1'b1, fib[m_pos], fib[m_pos + 1], 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_match_cnt"}, match_cnt, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_idx"}, err_idx, 0);
    check({tag, "_err_exp"}, err_exp, 0);
    check({tag, "_err_got"}, err_got, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  // Monitor: compare registered status after every edge that has a prediction.
  initial begin : monitor
    status_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("busy", busy, e.busy);
        check("match_cnt", match_cnt, e.mcnt);
        check("err", err, e.err);
        check("err_idx", err_idx, e.idx);
        check("err_exp", err_exp, e.eexp);
        check("err_got", err_got, e.egot);
      end
    end
  end

  initial begin : stim
    int len;
    fib[0] = 1;
    fib[1] = 1;
    for (int i = 2; i < 1024; i++) fib[i] = (fib[i-1] + fib[i-2]) % 65536;
    model_reset();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_num = '0;
`ifdef FIB_CHECK_DUAL_EN
    in_num2 = '0;
`endif
    #23;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // Clean prefix 1,1,2,3,5,8 back to back.
    for (int i = 0; i < 6; i++) good_beat();
    idle();

`ifdef FIB_CHECK_DUAL_EN
    // Pairs (1,1), (2,3), (5,9): lane 1 of the third beat is wrong.
    drive(1'b0, 0, 0, 1'b1);
    drive(1'b1, 1, 1, 1'b0);
    drive(1'b1, 2, 3, 1'b0);
    drive(1'b1, 5, 9, 1'b0);
    drive(1'b1, 8, 13, 1'b0);
    idle();
`else
    // 1,1,2,4,5: mismatch on index 3, the 5 is stalled.
    drive(1'b0, 0, 0, 1'b1);
    drive(1'b1, 1, 0, 1'b0);
    drive(1'b1, 1, 0, 1'b0);
    drive(1'b1, 2, 0, 1'b0);
    drive(1'b1, 4, 0, 1'b0);
    drive(1'b1, 5, 0, 1'b0);
    drive(1'b1, 5, 0, 1'b0);
    idle();
`endif

    // Wrap-around: indices 0..24 (index 24 is 75025 mod 2^16).
    drive(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 25; i += LANES) good_beat();
    idle();

    // clear with a valid beat pending: beat refused, then stream restarts at 1.
    drive(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) good_beat();
    drive(1'b1, fib[m_pos], fib[m_pos + 1], 1'b1);
    good_beat();
    idle();

    // Asynchronous reset between edges, then restart from 1.
    good_beat();
    idle();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async");
    sb_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    good_beat();
    good_beat();
    idle();

    // Randomised rounds: gaps, occasional corrupt values, beats after a stall.
    for (int r = 0; r < 30; r++) begin
      drive(1'b0, 0, 0, 1'b1);
      len = $urandom_range(40, 5);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3, 0) == 0) begin
          drive(1'b0, $urandom_range(65535, 0), 0, 1'b0);
        end else if ($urandom_range(20, 0) == 0) begin
          drive(1'b1, $urandom_range(65535, 0), fib[m_pos + 1], 1'b0);
        end else if ($urandom_range(20, 0) == 0) begin
          drive(1'b1, fib[m_pos], $urandom_range(65535, 0), 1'b0);
        end else begin
          good_beat();
        end
      end
      idle();
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
